// File: rtl/queen_solver_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : queen_solver_ctrl
// Description : Row-by-row backtracking sequencer for the N-Queen datapath;
//               drives the row decoder once per queen placement.
// Revision    : 1.0 - initial release
// ============================================================================
module queen_solver_ctrl #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           next,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic           dec_en,
    output logic [W-1:0]   dec_sel,
    output logic [W-1:0]   col_out,
    output logic [N*W-1:0] queen_pos
);

    localparam logic [2:0]   c_idle  = 3'd0;
    localparam logic [2:0]   c_check = 3'd1;
    localparam logic [2:0]   c_place = 3'd2;
    localparam logic [2:0]   c_back  = 3'd3;
    localparam logic [2:0]   c_done  = 3'd4;
    localparam logic [W-1:0] c_last  = W'(N - 1);
    localparam logic [W-1:0] c_one   = W'(1);

    logic [2:0]   r_state;
    logic [W-1:0] r_row;
    logic [W-1:0] r_col;
    logic [W-1:0] r_pos [N];
    logic         r_found;
    logic         r_busy;
    logic         r_done;

    logic [2:0]   w_state_nxt;
    logic [W-1:0] w_row_nxt;
    logic [W-1:0] w_col_nxt;
    logic         w_found_nxt;
    logic         w_clear;
    logic         w_place;
    logic         w_safe;
    logic [W:0]   w_rdiff;
    logic [W:0]   w_cdiff;
    logic [W-1:0] w_prev_row;
    logic [W-1:0] w_prev_pos;

    // Only rows above the current one hold placed queens.
    always_comb begin
        w_safe  = 1'b1;
        w_rdiff = '0;
        w_cdiff = '0;
        for (int i = 0; i < N; i++) begin
            w_rdiff = {1'b0, r_row} - (W+1)'(i);
            w_cdiff = (r_pos[i] > r_col) ? ({1'b0, r_pos[i]} - {1'b0, r_col})
                                         : ({1'b0, r_col} - {1'b0, r_pos[i]});
            if (((W+1)'(i) < {1'b0, r_row}) &&
                ((r_pos[i] == r_col) || (w_rdiff == w_cdiff)))
                w_safe = 1'b0;
        end
    end

    assign w_prev_row = r_row - c_one;
    assign w_prev_pos = r_pos[w_prev_row];

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_found_nxt = r_found;
        w_clear     = 1'b0;
        w_place     = 1'b0;
        case (r_state)
            c_idle, c_done: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_found_nxt = 1'b0;
                    w_state_nxt = c_check;
                end else if ((r_state == c_done) && next && r_found) begin
                    w_row_nxt = c_last;
                    if (r_pos[c_last] == c_last) begin
                        w_state_nxt = c_back;
                    end else begin
                        w_col_nxt   = r_pos[c_last] + c_one;
                        w_state_nxt = c_check;
                    end
                end
            end
            c_check: begin
                if (w_safe)               w_state_nxt = c_place;
                else if (r_col == c_last) w_state_nxt = c_back;
                else                      w_col_nxt   = r_col + c_one;
            end
            c_place: begin
                w_place = 1'b1;
                if (r_row == c_last) begin
                    w_found_nxt = 1'b1;
                    w_state_nxt = c_done;
                end else begin
                    w_row_nxt   = r_row + c_one;
                    w_col_nxt   = '0;
                    w_state_nxt = c_check;
                end
            end
            c_back: begin
                if (r_row == '0) begin
                    w_found_nxt = 1'b0;
                    w_state_nxt = c_done;
                end else begin
                    w_row_nxt = w_prev_row;
                    // A row already at its last column keeps unwinding upward.
                    if (w_prev_pos != c_last) begin
                        w_col_nxt   = w_prev_pos + c_one;
                        w_state_nxt = c_check;
                    end
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row   <= '0;
            r_col   <= '0;
            r_found <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < N; i++) r_pos[i] <= '0;
        end else begin
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_found <= w_found_nxt;
            r_busy  <= (w_state_nxt == c_check) || (w_state_nxt == c_place) ||
                       (w_state_nxt == c_back);
            r_done  <= (w_state_nxt == c_done);
            if (w_clear) begin
                for (int i = 0; i < N; i++) r_pos[i] <= '0;
            end else if (w_place) begin
                r_pos[r_row] <= r_col;
            end
        end
    end

    always_comb begin
        dec_en  = (r_state == c_place);
        dec_sel = dec_en ? r_row : '0;
        col_out = dec_en ? r_col : '0;
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign found = r_found;

    for (genvar g = 0; g < N; g++) begin : g_pos
        assign queen_pos[g*W +: W] = r_pos[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_queen_solver_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_queen_solver_ctrl
// Description : Directed self-checking bench for queen_solver_ctrl (N=8,4,3,1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queen_solver_ctrl;

    localparam int c_limit = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start_v;
    logic [3:0]  next_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  found_v;
    logic [3:0]  dec_en_v;
    logic [2:0]  dec_sel8, col_out8;
    logic [1:0]  dec_sel4, col_out4, dec_sel3, col_out3;
    logic [0:0]  dec_sel1, col_out1;
    logic [23:0] q8;
    logic [7:0]  q4;
    logic [5:0]  q3;
    logic [0:0]  q1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    queen_solver_ctrl #(.N(8), .W(3)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .next(next_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .found(found_v[0]),
        .dec_en(dec_en_v[0]), .dec_sel(dec_sel8), .col_out(col_out8), .queen_pos(q8));
    queen_solver_ctrl #(.N(4), .W(2)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .next(next_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .found(found_v[1]),
        .dec_en(dec_en_v[1]), .dec_sel(dec_sel4), .col_out(col_out4), .queen_pos(q4));
    queen_solver_ctrl #(.N(3), .W(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_v[2]), .next(next_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .found(found_v[2]),
        .dec_en(dec_en_v[2]), .dec_sel(dec_sel3), .col_out(col_out3), .queen_pos(q3));
    queen_solver_ctrl #(.N(1), .W(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[3]), .next(next_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .found(found_v[3]),
        .dec_en(dec_en_v[3]), .dec_sel(dec_sel1), .col_out(col_out1), .queen_pos(q1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pack8(input int a[8]);
        logic [23:0] v = '0;
        for (int i = 0; i < 8; i++) v[i*3 +: 3] = 3'(a[i]);
        return v;
    endfunction

    // Independent column / diagonal legality of a full 8x8 board.
    function automatic logic valid8(input logic [23:0] q);
        int ci, cj, d;
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++) begin
                ci = int'(q[i*3 +: 3]);
                cj = int'(q[j*3 +: 3]);
                d  = (ci > cj) ? ci - cj : cj - ci;
                if (ci == cj || d == j - i) return 1'b0;
            end
        return 1'b1;
    endfunction

    task automatic pulse(input int k, input bit is_next);
        @(negedge clk);
        if (is_next) next_v[k] = 1'b1; else start_v[k] = 1'b1;
        @(negedge clk);
        next_v[k]  = 1'b0;
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input bit disturb, output int cyc);
        cyc = 0;
        while (!done_v[k] && cyc < c_limit) begin
            if (disturb) begin
                start_v[k] = 1'($urandom);
                next_v[k]  = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start_v[k] = 1'b0;
        next_v[k]  = 1'b0;
        chk($sformatf("done_timeout_dut%0d", k), done_v[k], 1);
    endtask

    // Every PLACE pulse on the 8-board must land col_out in row dec_sel.
    logic       rst_q = 1'b0;
    logic       pend = 1'b0;
    logic [2:0] psel, pcol;
    int         row2_places3 = 0;
    int         places3 = 0;
    always @(posedge clk) rst_q <= rst;
    always @(negedge clk) begin
        if (pend && !rst_q)
            chk("place_write", q8[int'(psel)*3 +: 3], pcol);
        pend = dec_en_v[0];
        psel = dec_sel8;
        pcol = col_out8;
        if (dec_en_v[2]) begin
            places3++;
            if (dec_sel3 == 2'd2) row2_places3++;
        end
    end

    int          sol8[8] = '{0, 4, 7, 5, 2, 6, 1, 3};
    logic [23:0] exp8;
    int          cyc_ref, cyc, nsol;
    bit          ex;

    initial begin
        rst     = 1'b1;
        start_v = '0;
        next_v  = '0;
        exp8    = pack8(sol8);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy",    busy_v[0], 0);
        chk("rst_done",    done_v[0], 0);
        chk("rst_found",   found_v[0], 0);
        chk("rst_dec_en",  dec_en_v[0], 0);
        chk("rst_dec_sel", dec_sel8, 0);
        chk("rst_col_out", col_out8, 0);
        chk("rst_qpos",    q8, 0);

        pulse(0, 0);
        wait_done(0, 0, cyc_ref);
        chk("first_found", found_v[0], 1);
        chk("first_board", q8, exp8);

        nsol = 1;
        ex   = 0;
        for (int k = 0; k < 100 && !ex; k++) begin
            pulse(0, 1);
            wait_done(0, 0, cyc);
            if (!done_v[0] || !found_v[0]) ex = 1;
            else begin
                nsol++;
                chk("board_valid", valid8(q8), 1);
            end
        end
        chk("solution_count", nsol, 92);
        chk("exhausted_found", found_v[0], 0);

        pulse(0, 1);
        repeat (3) @(negedge clk);
        chk("next_ignored_done", done_v[0], 1);
        chk("next_ignored_busy", busy_v[0], 0);

        pulse(0, 0);
        wait_done(0, 0, cyc);
        chk("restart_found",  found_v[0], 1);
        chk("restart_board",  q8, exp8);
        chk("restart_cycles", cyc, cyc_ref);

        pulse(0, 0);
        wait_done(0, 1, cyc);
        chk("disturbed_found",  found_v[0], 1);
        chk("disturbed_board",  q8, exp8);
        chk("disturbed_cycles", cyc, cyc_ref);

        pulse(0, 0);
        repeat (50) @(negedge clk);
        chk("midsearch_busy", busy_v[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",  busy_v[0], 0);
        chk("midrst_done",  done_v[0], 0);
        chk("midrst_found", found_v[0], 0);
        chk("midrst_qpos",  q8, 0);
        pulse(0, 0);
        wait_done(0, 0, cyc);
        chk("post_rst_board", q8, exp8);

        pulse(1, 0);
        wait_done(1, 0, cyc);
        chk("n4_sol1_found", found_v[1], 1);
        chk("n4_sol1_board", q4, 8'h8D);
        pulse(1, 1);
        wait_done(1, 0, cyc);
        chk("n4_sol2_found", found_v[1], 1);
        chk("n4_sol2_board", q4, 8'h72);
        pulse(1, 1);
        wait_done(1, 0, cyc);
        chk("n4_exhausted", found_v[1], 0);

        pulse(2, 0);
        wait_done(2, 0, cyc);
        chk("n3_found",      found_v[2], 0);
        chk("n3_row2_place", row2_places3, 0);
        chk("n3_some_place", places3 > 0, 1);

        pulse(3, 0);
        wait_done(3, 0, cyc);
        chk("n1_found", found_v[3], 1);
        chk("n1_board", q1, 0);
        pulse(3, 1);
        wait_done(3, 0, cyc);
        chk("n1_exhausted", found_v[3], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
